// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side master for sync_fifo.
// Pops exactly len words from the FIFO on a start command and streams them
// downstream on a valid/ready interface. The FIFO's one-cycle registered read
// latency is absorbed by a 2-entry skid buffer. Pops are issued on credit, so
// the block sustains one word per cycle and still never overruns the buffer.

module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  state_t                 state;
  state_t                 state_next;

  logic [CNT_WIDTH-1:0]   len_q;
  logic [CNT_WIDTH-1:0]   issued;
  logic [CNT_WIDTH-1:0]   delivered;

  // A pop issued last cycle: its data appears on fifo_rdata this cycle.
  logic                   inflight;

  // Skid buffer: head feeds m_data, tail only fills when the head is stalled.
  logic [1:0]             occ;
  logic [DATA_WIDTH-1:0]  skid_head;
  logic [DATA_WIDTH-1:0]  skid_tail;

  logic                   pop_now;
  logic                   capture;
  logic                   last_handshake;
  logic                   accept_start;
  logic [2:0]             credit;

  // Handshake, capture and credit terms shared by the FSM and the datapath.
  always_comb begin
    pop_now        = m_valid && m_ready;
    capture        = inflight;
    last_handshake = pop_now && ((delivered + CNT_ONE) == len_q);
    accept_start   = (state == IDLE) && start;
    credit         = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop_now};
  end

  // Pop request: only while running, only with data available, only while
  // words remain to be fetched, and only when the skid buffer has room for
  // everything already committed (held words plus the word in flight).
  always_comb begin
    fifo_rd_en = 1'b0;
    if ((state == RUN) && !fifo_empty && (issued < len_q) && (credit < 3'd2)) begin
      fifo_rd_en = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a zero-length burst skips straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == CNT_ZERO) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_handshake) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state and the skid buffer.
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    m_valid = (occ != 2'd0);
    m_data  = skid_head;
  end

  // Burst counters: latched on an accepted start, then advanced per pop
  // and per downstream handshake. words_out keeps its value after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= CNT_ZERO;
      issued    <= CNT_ZERO;
      delivered <= CNT_ZERO;
      words_out <= CNT_ZERO;
    end else if (accept_start) begin
      len_q     <= len;
      issued    <= CNT_ZERO;
      delivered <= CNT_ZERO;
      words_out <= CNT_ZERO;
    end else begin
      if (fifo_rd_en) begin
        issued <= issued + CNT_ONE;
      end
      if (pop_now) begin
        delivered <= delivered + CNT_ONE;
        words_out <= words_out + CNT_ONE;
      end
    end
  end

  // Track the pop that is one cycle away from producing read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // Skid buffer update; capture and pop together keep occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= 2'd0;
      skid_head <= '0;
      skid_tail <= '0;
    end else begin
      case ({capture, pop_now})
        2'b10: begin
          if (occ == 2'd0) begin
            skid_head <= fifo_rdata;
            occ       <= 2'd1;
          end else begin
            skid_tail <= fifo_rdata;
            occ       <= 2'd2;
          end
        end
        2'b01: begin
          if (occ == 2'd2) begin
            skid_head <= skid_tail;
            occ       <= 2'd1;
          end else begin
            occ       <= 2'd0;
          end
        end
        2'b11: begin
          if (occ == 2'd2) begin
            skid_head <= skid_tail;
            skid_tail <= fifo_rdata;
          end else begin
            skid_head <= fifo_rdata;
          end
        end
        default: begin
          occ <= occ;
        end
      endcase
    end
  end

endmodule
